// File: rtl/robo_pkg.sv
// robo_pkg: encodings shared by the wall-following controller and the motor
// driver that sits behind it.
//   motion_e      - motor driver states (2-bit)
//   CMD_*         - {front, rotate} command codes emitted by the controller
//   ctrl_state_e  - controller Moore state names, kept here so both blocks
//                   decode the same names
//   decode_cmd()  - maps {front, rotate} onto the motion it requests
package robo_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    FWD   = 2'b01,
    ROT   = 2'b10,
    BRAKE = 2'b11
  } motion_e;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_ROT  = 2'b01;
  localparam logic [1:0] CMD_FWD  = 2'b10;
  localparam logic [1:0] CMD_BAD  = 2'b11;

  typedef enum logic [1:0] {
    CTRL_SEEK   = 2'b00,
    CTRL_FOLLOW = 2'b01,
    CTRL_TURN   = 2'b10
  } ctrl_state_e;

  // Both-high is contradictory, so it is treated exactly like a stop request.
  function automatic motion_e decode_cmd(input logic front, input logic rotate);
    case ({front, rotate})
      CMD_FWD: return FWD;
      CMD_ROT: return ROT;
      default: return STOP;
    endcase
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM counter with a registered compare.
//   clk, rst     - clock, asynchronous active-high reset
//   duty_i       - high time in counter ticks (0 = constant low)
//   force_low_i  - forces the output low on the coming edge
//   pwm_o        - registered PWM output, one clock behind cnt/duty
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic                force_low_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic                pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= !force_low_i && (cnt_q < duty_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_driver.sv
// motor_driver: turns the controller's {front, rotate} command into wheel
// PWM and direction, with a soft-start duty ramp and a fixed brake interval
// between any two different motions.
//   clk, rst         - clock, asynchronous active-high reset
//   front_i          - forward command
//   rotate_i         - rotate (turn right) command
//   pwm_l_o, pwm_r_o - wheel PWM (identical; direction tells them apart)
//   dir_l_o, dir_r_o - wheel direction, 1 = forward
//   moving_o         - driving (FWD/ROT) with non-zero duty
module motor_driver #(
  parameter int PWM_BITS    = 8,
  parameter int FWD_DUTY    = 240,
  parameter int ROT_DUTY    = 128,
  parameter int RAMP_STEP   = 16,
  parameter int RAMP_DIV    = 1024,
  parameter int DEAD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic front_i,
  input  logic rotate_i,
  output logic pwm_l_o,
  output logic pwm_r_o,
  output logic dir_l_o,
  output logic dir_r_o,
  output logic moving_o
);
  import robo_pkg::*;

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] FWD_TGT  = PWM_BITS'(FWD_DUTY);
  localparam logic [PWM_BITS-1:0] ROT_TGT  = PWM_BITS'(ROT_DUTY);
  localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS+1)'(RAMP_STEP);
  localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  motion_e             state_q, state_d, cmd;
  logic [PWM_BITS-1:0] duty_q, duty_d, target;
  logic [PWM_BITS:0]   duty_sum;
  logic [RW-1:0]       ramp_cnt_q, ramp_cnt_d;
  logic [DW-1:0]       dead_cnt_q, dead_cnt_d;
  logic                dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic                moving_q, moving_d;
  logic                launch, run_d, pwm;

  always_comb begin
    cmd        = decode_cmd(front_i, rotate_i);
    target     = (state_q == FWD) ? FWD_TGT : ROT_TGT;
    // One extra bit so a step past the top of the range still compares
    // correctly against the target instead of wrapping.
    duty_sum   = {1'b0, duty_q} + STEP_EXT;
    state_d    = state_q;
    duty_d     = duty_q;
    ramp_cnt_d = ramp_cnt_q;
    dead_cnt_d = dead_cnt_q;
    dir_l_d    = dir_l_q;
    dir_r_d    = dir_r_q;
    launch     = 1'b0;

    case (state_q)
      FWD, ROT: begin
        if (cmd != state_q) begin
          state_d    = BRAKE;
          duty_d     = '0;
          ramp_cnt_d = '0;
          dead_cnt_d = DEAD_LOAD;
        end else if (ramp_cnt_q == RAMP_LAST) begin
          ramp_cnt_d = '0;
          duty_d     = (duty_sum > {1'b0, target}) ? target : duty_sum[PWM_BITS-1:0];
        end else begin
          ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
      end
      BRAKE: begin
        duty_d     = '0;
        ramp_cnt_d = '0;
        // The interval always runs to completion; only the command present
        // on the final edge decides where we go.
        if (dead_cnt_q != '0) dead_cnt_d = dead_cnt_q - 1'b1;
        else                  launch     = 1'b1;
      end
      default: begin
        duty_d     = '0;
        ramp_cnt_d = '0;
        launch     = 1'b1;
      end
    endcase

    // Leaving STOP/BRAKE: PWM is already low, so directions may change on
    // the same edge as the state.
    if (launch) begin
      state_d = cmd;
      if (cmd == FWD) begin
        dir_l_d = 1'b1;
        dir_r_d = 1'b1;
      end else if (cmd == ROT) begin
        dir_l_d = 1'b1;
        dir_r_d = 1'b0;
      end
    end

    run_d    = (state_d == FWD) || (state_d == ROT);
    moving_d = run_d && (duty_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= STOP;
      duty_q     <= '0;
      ramp_cnt_q <= '0;
      dead_cnt_q <= '0;
      dir_l_q    <= 1'b1;
      dir_r_q    <= 1'b1;
      moving_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      ramp_cnt_q <= ramp_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      dir_l_q    <= dir_l_d;
      dir_r_q    <= dir_r_d;
      moving_q   <= moving_d;
    end
  end

  // force_low uses the next state so the pins drop on the entry edge
  // into STOP/BRAKE rather than one clock later.
  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .duty_i     (duty_q),
    .force_low_i(!run_d),
    .pwm_o      (pwm)
  );

  assign pwm_l_o  = pwm;
  assign pwm_r_o  = pwm;
  assign dir_l_o  = dir_l_q;
  assign dir_r_o  = dir_r_q;
  assign moving_o = moving_q;

endmodule
